// File: rtl/stopwatch_control_pkg.sv
// Shared definitions for the stopwatch control stage.
//   state_e               : FSM state; the encoding is also the external status code
//   DefaultDebounceCycles : stable cycles before a button level is accepted (10 ms @ 100 MHz)
//   ValueW                : width of the counter value / displayed number (0..9999)
package stopwatch_control_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StLap     = 2'd2,
        StStopped = 2'd3
    } state_e;

    localparam int unsigned DefaultDebounceCycles = 1000000;
    localparam int unsigned ValueW                = 14;

endpackage

// File: rtl/stopwatch_control_button_debouncer.sv
// Debouncer for one raw push-button.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   in      : raw button level, asynchronous to clk
//   pressed : one-cycle pulse on each accepted rising edge of the debounced level
module button_debouncer
    import stopwatch_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pressed
);

    localparam int unsigned     CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            pressed_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= in;
            sync2_q   <= sync1_q;
            pressed_q <= 1'b0;
            if (sync2_q == stable_q) begin
                // Any agreeing sample restarts the count, so glitches never accumulate.
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                stable_q  <= sync2_q;
                cnt_q     <= '0;
                pressed_q <= sync2_q;  // pulse only on the press edge, not on release
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: debounces start/stop, lap and clear buttons and runs the
// IDLE/RUNNING/LAP/STOPPED state machine driving the tenth-second counter.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   btn_start_stop, btn_lap, btn_clear: raw active-high buttons
//   count_value                       : live counter value
//   count_enable                      : counter run enable (registered)
//   count_clear                       : one-cycle counter clear pulse (registered)
//   display_value                     : number for the 7-segment mux (registered)
//   status                            : current state code
module stopwatch_control
    import stopwatch_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned VALUE_W         = ValueW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    input  logic [VALUE_W-1:0] count_value,
    output logic               count_enable,
    output logic               count_clear,
    output logic [VALUE_W-1:0] display_value,
    output logic [1:0]         status
);

    logic press_ss;
    logic press_lap;
    logic press_clr;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (btn_start_stop),
        .pressed (press_ss)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (btn_lap),
        .pressed (press_lap)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (btn_clear),
        .pressed (press_clr)
    );

    // Only the highest-priority pulse survives: clear > start_stop > lap.
    logic ev_ss;
    logic ev_lap;
    assign ev_ss  = press_ss & ~press_clr;
    assign ev_lap = press_lap & ~press_ss & ~press_clr;

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] lap_q, lap_d;
    logic               clr_d;
    logic               en_q;
    logic               clr_q;
    logic [VALUE_W-1:0] display_q;

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press_clr) begin
                    clr_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = StRunning;
                end
            end
            StRunning: begin
                if (ev_ss) begin
                    state_d = StStopped;
                end else if (ev_lap) begin
                    state_d = StLap;
                    lap_d   = count_value;
                end
            end
            StLap: begin
                if (ev_ss) begin
                    state_d = StStopped;
                end else if (ev_lap) begin
                    state_d = StRunning;
                end
            end
            StStopped: begin
                if (press_clr) begin
                    state_d = StIdle;
                    clr_d   = 1'b1;
                end else if (ev_ss) begin
                    state_d = StRunning;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lap_q     <= '0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            display_q <= '0;
        end else begin
            state_q   <= state_d;
            lap_q     <= lap_d;
            // Outputs follow the next state so they change on the same edge as status.
            en_q      <= (state_d == StRunning) || (state_d == StLap);
            clr_q     <= clr_d;
            display_q <= (state_d == StLap) ? lap_d : count_value;
        end
    end

    assign count_enable  = en_q;
    assign count_clear   = clr_q;
    assign display_value = display_q;
    assign status        = state_q;

endmodule
